// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes, instruction kinds, field positions,
// and the kind-to-word encoder used by the program loader.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    typedef enum logic [3:0] {
        KIND_R    = 4'd0,
        KIND_LW   = 4'd1,
        KIND_SW   = 4'd2,
        KIND_BEQ  = 4'd3,
        KIND_BNE  = 4'd4,
        KIND_J    = 4'd5,
        KIND_ADDI = 4'd6,
        KIND_ANDI = 4'd7
    } kind_e;

    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned TGT_LSB   = 0;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    function automatic enc_t encode_instr(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [25:0] imm
    );
        enc_t       e;
        logic [5:0] op;
        logic       itype;
        e     = '0;
        e.legal = 1'b1;
        op    = OP_RTYPE;
        itype = 1'b0;
        case (kind)
            KIND_R: begin
                e.word[RS_LSB    +: 5] = rs;
                e.word[RT_LSB    +: 5] = rt;
                e.word[RD_LSB    +: 5] = rd;
                e.word[SHAMT_LSB +: 5] = shamt;
                e.word[FUNCT_LSB +: 6] = funct;
            end
            KIND_LW:   begin op = OP_LW;   itype = 1'b1; end
            KIND_SW:   begin op = OP_SW;   itype = 1'b1; end
            KIND_BEQ:  begin op = OP_BEQ;  itype = 1'b1; end
            KIND_BNE:  begin op = OP_BNE;  itype = 1'b1; end
            KIND_ADDI: begin op = OP_ADDI; itype = 1'b1; end
            KIND_ANDI: begin op = OP_ANDI; itype = 1'b1; end
            KIND_J: begin
                op = OP_J;
                e.word[TGT_LSB +: 26] = imm;
            end
            default: e.legal = 1'b0;
        endcase
        if (itype) begin
            e.word[RS_LSB  +: 5]  = rs;
            e.word[RT_LSB  +: 5]  = rt;
            e.word[IMM_LSB +: 16] = imm[15:0];
        end
        if (e.legal) begin
            e.word[OP_LSB +: 6] = op;
        end
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head shows the oldest entry without popping.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    // Pointer and storage update; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) begin
                mem_q[wptr_q[AW-1:0]] <= din;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes instruction descriptions into MIPS words and streams them into
// instruction memory through a stallable write port.
module instr_encode_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;
    logic              err_q;
    logic [PW-1:0]     pend_q;
    logic [PW-1:0]     pend_d;

    enc_t        enc;
    logic        active;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic        accept;
    logic        push;
    logic        wr_fire;

    assign enc = encode_instr(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm);

    assign active    = (state_q == LOAD) || (state_q == DRAIN);
    assign in_ready  = (state_q == LOAD) && !fifo_full;
    assign accept    = in_valid && in_ready && !start;
    assign push      = accept && enc.legal;
    assign mem_we    = active && !fifo_empty;
    assign wr_fire   = mem_we && mem_ready && !start;
    assign mem_wdata = mem_we ? fifo_head : '0;
    assign mem_addr  = addr_q;
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign count     = count_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (push),
        .din   (enc.word),
        .pop   (wr_fire),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Occupancy after this edge, so DRAIN can leave on the edge that empties the FIFO.
    always_comb begin
        pend_d = pend_q;
        if (push && !wr_fire) begin
            pend_d = pend_q + PW'(1);
        end else if (wr_fire && !push) begin
            pend_d = pend_q - PW'(1);
        end
    end

    // Session FSM, address/count tracking and sticky error; start overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
        end else if (start) begin
            state_q <= LOAD;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_fire) begin
                addr_q  <= addr_q + ADDR_W'(4);
                count_q <= count_q + ADDR_W'(1);
            end
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (!enc.legal) begin
                            err_q <= 1'b1;
                        end
                        if (in_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pend_d == '0) begin
                        state_q <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: a driver pushes expected writes
// computed by an arithmetic reference encoder; a monitor checks every write.
module tb_instr_encode_loader;

    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, in_last, mem_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [25:0] in_imm;

    logic        in_ready0, mem_we0, done0, err0;
    logic [31:0] mem_addr0, mem_wdata0, count0;
    logic        in_ready1, mem_we1, done1, err1;
    logic [31:0] mem_addr1, mem_wdata1, count1;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          exp_cnt = 0;
    bit          exp_err = 0;
    int          mode = 0;

    instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_ready(mem_ready),
        .done(done0), .err(err0), .count(count0)
    );

    instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(BASE1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ready(mem_ready),
        .done(done1), .err(err1), .count(count1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference encoder: MIPS field weights as plain multiplications.
    function automatic logic [32:0] ref_encode(input int unsigned kind, rs, rt, rd, sh, fn, imm);
        int unsigned op;
        case (kind)
            0: return {1'b1, 32'(rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn)};
            5: return {1'b1, 32'(2 * 67108864 + imm)};
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 5;
            6: op = 8;
            7: op = 12;
            default: return 33'd0;
        endcase
        return {1'b1, 32'(op * 67108864 + rs * 2097152 + rt * 65536 + (imm % 65536))};
    endfunction

    // Memory-side responder: always ready, random, or stalled.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: mem_ready = 1'b1;
                1: mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every presented write must match the scoreboard head; pop on completion.
    always @(negedge clk) begin
        if (rst_n && !start) begin
            if (mem_we0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0_unexpected_write actual=%0h@%0h expected=none", mem_wdata0, mem_addr0);
                end else begin
                    check("dut0_addr", mem_addr0, q0[0][63:32]);
                    check("dut0_data", mem_wdata0, q0[0][31:0]);
                    if (mem_ready) void'(q0.pop_front());
                end
            end
            if (mem_we1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_unexpected_write actual=%0h@%0h expected=none", mem_wdata1, mem_addr1);
                end else begin
                    check("dut1_addr", mem_addr1, q1[0][63:32]);
                    check("dut1_data", mem_wdata1, q1[0][31:0]);
                    if (mem_ready) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic start_session();
        @(posedge clk);
        #1 start = 1'b1;
        q0.delete();
        q1.delete();
        exp_cnt = 0;
        exp_err = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drive_fields(input int kind, rs, rt, rd, sh, fn, imm, input bit last);
        in_kind  = 4'(kind);
        in_rs    = 5'(rs);
        in_rt    = 5'(rt);
        in_rd    = 5'(rd);
        in_shamt = 5'(sh);
        in_funct = 6'(fn);
        in_imm   = 26'(imm);
        in_last  = last;
        in_valid = 1'b1;
    endtask

    // ovr[32] set: use ovr[31:0] as the expected word instead of the model.
    task automatic send_beat(input int kind, rs, rt, rd, sh, fn, imm, input bit last,
                             input logic [32:0] ovr);
        bit          acc;
        logic [32:0] m;
        acc = 1'b0;
        drive_fields(kind, rs, rt, rd, sh, fn, imm, last);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready0) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout actual=in_ready_low expected=accepted");
        end else begin
            m = ref_encode(kind, rs, rt, rd, sh, fn, imm);
            if (m[32]) begin
                if (ovr[32]) m[31:0] = ovr[31:0];
                q0.push_back({32'(exp_cnt * 4), m[31:0]});
                q1.push_back({BASE1 + 32'(exp_cnt * 4), m[31:0]});
                exp_cnt++;
            end else begin
                exp_err = 1'b1;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic rand_beat(input int kmax, input bit last);
        send_beat($urandom_range(0, kmax), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 67108863), last, 33'd0);
    endtask

    task automatic end_session(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, got, 1);
        check({tag, "_count0"}, count0, exp_cnt);
        check({tag, "_count1"}, count1, exp_cnt);
        check({tag, "_err"}, err0, exp_err);
        check({tag, "_sb_empty"}, q0.size() + q1.size(), 0);
        check({tag, "_idle_ports"}, {in_ready0, mem_we0, done1}, 3'b001);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_funct = '0; in_imm = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_flags", {in_ready0, mem_we0, done0, err0}, 4'b0000);
        check("reset_wdata", mem_wdata0, 0);
        check("reset_count", count0, 0);
        check("reset_addr0", mem_addr0, 0);
        check("reset_addr1", mem_addr1, BASE1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // IDLE ignores beats
        drive_fields(0, 1, 2, 3, 0, 32, 0, 1'b1);
        @(negedge clk);
        check("idle_ignores", {in_ready0, mem_we0, done0}, 3'b000);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;

        // R add, single word, done one cycle after the write
        mode = 0;
        start_session();
        send_beat(0, 1, 2, 3, 0, 32'h20, 0, 1'b1, {1'b1, 32'h0022_1820});
        @(negedge clk);
        check("radd_we_before_done", {mem_we0, done0}, 2'b10);
        @(negedge clk);
        check("radd_done_after_write", {done0, count0}, {1'b1, 32'd1});
        end_session("radd");

        // LW then J
        start_session();
        send_beat(1, 29, 8, 0, 0, 0, 32'h0004, 1'b0, {1'b1, 32'h8FA8_0004});
        send_beat(5, 0, 0, 0, 0, 0, 32'h10, 1'b1, {1'b1, 32'h0800_0010});
        end_session("lw_j");

        // Backpressure: FIFO fills after 4 beats, write port holds steady
        mode = 2;
        start_session();
        for (int i = 0; i < 4; i++) rand_beat(7, 1'b0);
        drive_fields(6, 7, 9, 0, 0, 0, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready_low", in_ready0, 0);
            check("full_mem_we", mem_we0, 1);
        end
        mode = 0;
        send_beat(6, 7, 9, 0, 0, 0, 16'h1234, 1'b0, 33'd0);
        rand_beat(7, 1'b1);
        end_session("full");

        // Illegal kind sandwiched between ADDI and ANDI
        start_session();
        send_beat(6, 0, 4, 0, 0, 0, 16'hFFFF, 1'b0, {1'b1, 32'h2004_FFFF});
        send_beat(9, 3, 3, 3, 3, 3, 3, 1'b0, 33'd0);
        send_beat(7, 4, 5, 0, 0, 0, 16'h00FF, 1'b1, {1'b1, 32'h3085_00FF});
        end_session("illegal");

        // BEQ/BNE: dut1 address wraps from 0xFFFFFFFC to 0
        start_session();
        send_beat(3, 8, 9, 0, 0, 0, 16'hFFFE, 1'b0, 33'd0);
        send_beat(4, 10, 11, 0, 0, 0, 16'h0003, 1'b1, 33'd0);
        end_session("wrap");

        // Random sessions with random memory stalls and occasional illegal kinds
        mode = 1;
        for (int s = 0; s < 6; s++) begin
            int n;
            n = $urandom_range(1, 8);
            start_session();
            for (int b = 0; b < n; b++) rand_beat(9, b == n - 1);
            end_session("random");
        end

        // Restart mid-DRAIN discards buffered words and clears err
        mode = 2;
        start_session();
        rand_beat(7, 1'b0);
        send_beat(12, 0, 0, 0, 0, 0, 0, 1'b0, 33'd0);
        rand_beat(7, 1'b1);
        @(negedge clk);
        check("drain_state", {in_ready0, mem_we0, err0}, 3'b011);
        mode = 0;
        start_session();
        @(negedge clk);
        check("restart_count", count0, 0);
        check("restart_flags", {in_ready0, err0, done0, mem_we0}, 4'b1000);
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-LOAD
        mode = 2;
        start_session();
        rand_beat(7, 1'b0);
        rand_beat(7, 1'b0);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("async_rst_flags", {in_ready0, mem_we0, done0, err0}, 4'b0000);
        check("async_rst_data", {mem_wdata0, mem_addr0}, 64'd0);
        check("async_rst_count", count0, 0);
        check("async_rst_addr1", mem_addr1, BASE1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mode = 0;
        @(negedge clk);
        check("post_rst_idle", {in_ready0, mem_we0, done0}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the main control decoder: takes instruction descriptions (kind plus fields) and encodes them into 32-bit MIPS words.
- Writes the encoded words sequentially into instruction memory through a stallable write port.
- Used by the bench and the boot path to load programs for the single-cycle core before it is released from reset.
- Covers the same eight instruction classes that the core decodes.

Parameters:
- ADDR_W, 32: width of mem_addr and of the address counter.
- BASE_ADDR, 32'h0000_0000: first byte address written after start.
- FIFO_DEPTH, 4: depth of the encoded-word buffer; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new load session.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready at a rising edge.
- in_kind  in  4  0=R, 1=LW, 2=SW, 3=BEQ, 4=BNE, 5=J, 6=ADDI, 7=ANDI; 8-15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  26  bits [15:0] hold the I-type immediate; all 26 bits hold the J target.
- in_last  in  1  marks the final beat of the program.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  32  encoded word.
- mem_ready  in  1  write completes on mem_we && mem_ready.
- done  out  1  session complete.
- err  out  1  sticky; set when an illegal kind is received during the session.
- count  out  ADDR_W  number of words written this session.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, FIFO empty, address counter=BASE_ADDR.
  - in_ready=0, mem_we=0, mem_wdata=0, done=0, err=0, count=0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE: in_ready=0. start moves to LOAD.
- Effects of start, from any state, including mid-LOAD/DRAIN:
  - FIFO flushed, address counter=BASE_ADDR, count=0, err=0, done=0, next state LOAD.
  - start has priority over a simultaneous beat and a simultaneous memory write; both are discarded and count does not increment.
- LOAD:
  - in_ready = !fifo_full. There is no pass-through when full, even if a pop occurs in the same cycle.
  - An accepted legal beat is encoded combinationally and pushed into the FIFO on that edge.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm[15:0]} with op LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, ANDI=001100.
  - J-type: {000010, imm[25:0]}. Fields not used by the kind are ignored.
- Illegal kind: the beat is consumed and nothing is pushed; err is set and holds until the next start or reset.
- An accepted beat with in_last=1 (legal or illegal) moves the FSM to DRAIN; in_ready=0 from the next cycle.
- Memory side, in LOAD and DRAIN:
  - mem_we = !fifo_empty; mem_wdata = FIFO head; mem_addr = address counter.
  - On mem_we && mem_ready: pop the head, address counter += 4 (wraps modulo 2^ADDR_W), count += 1.
  - mem_wdata and mem_addr must hold stable while mem_we=1 and mem_ready=0.
- Latency: a beat accepted at edge N produces mem_we=1 with its word in the cycle after edge N, at the earliest.
- DRAIN exits to DONE on the edge where the FIFO becomes empty, or immediately if it is already empty.
- DONE: done=1, mem_we=0, in_ready=0; the FSM stays in DONE until start.
- Simultaneous push and pop on a non-full FIFO: both take effect and occupancy is unchanged.
- Outside LOAD and DRAIN: mem_we=0, and in_valid is ignored.

Decomposition:
- Shared package mips_isa_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI);
  - kind encodings KIND_R..KIND_ANDI;
  - the instruction field bit positions.
- The control decoder also uses this package.
- One sub-module: sync_fifo (parameters WIDTH=32, DEPTH; clk, rst_n, flush, push, pop, full, empty, head).

Test Plan:
- Reset, then start; send R add (rs=1, rt=2, rd=3, shamt=0, funct=0x20, last=1) with mem_ready=1 -> one write, addr 0x0, data 0x00221820; done=1 and count=1 one cycle after the write.
- Send LW rs=29 rt=8 imm=0x0004, then J imm=0x0000010 with last; mem_ready=1 -> writes 0x8FA80004 @0x0, then 0x08000010 @0x4; count=2.
- Hold mem_ready=0 while streaming 6 beats (FIFO_DEPTH=4) -> in_ready drops after 4 accepts; mem_wdata/mem_addr stay stable; release mem_ready -> all 6 words land at 0x0..0x14 in order.
- Send in_kind=9 in the middle of ADDI(rs=0, rt=4, imm=0xFFFF) and ANDI(rs=4, rt=5, imm=0x00FF, last) -> err=1; only 0x2004FFFF @0x0 and 0x308500FF @0x4 are written; count=2.
- With BASE_ADDR=32'hFFFF_FFFC, write BEQ then BNE -> addresses 0xFFFFFFFC then 0x00000000 (wrap).
- Pulse start mid-DRAIN with 3 words buffered -> no further writes from the old session; count=0, err=0, in_ready=1 next cycle; assert rst_n low mid-LOAD -> all outputs 0 immediately.
